// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants, pixel width and rx state encoding.
// Imported by both the LED transmitter and the stream decoder.
package ws2812_pkg;

   localparam int T0H_CYC   = 20;
   localparam int T1H_CYC   = 40;
   localparam int BIT_CYC   = 62;
   localparam int RESET_LOW = 2500;
   localparam int GRB_W     = 24;

   typedef enum logic [1:0] {
      RX_SYNC = 2'd0,
      RX_IDLE = 2'd1,
      RX_HIGH = 2'd2,
      RX_LOW  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded-pixel output bundle of the WS2812 receiver.
// The master side is driven by the decoder; consumers take the slave side.
interface ws2812_rx_if;
   import ws2812_pkg::*;

   logic [GRB_W-1:0] pix_data;
   logic             pix_valid;
   logic [7:0]       pix_idx;
   logic             frame_done;
   logic [7:0]       frame_len;
   logic             bit_err;

   modport master (
      output pix_data, pix_valid, pix_idx,
      output frame_done, frame_len, bit_err
   );

   modport slave (
      input pix_data, pix_valid, pix_idx,
      input frame_done, frame_len, bit_err
   );

endinterface

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchronizer plus delay flop with rise/fall detection.
// Generic: also serves gesture-interrupt and key inputs.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;
   assign fall  = ~s2 & s3;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 one-wire stream decoder: pulse-width bit classification,
// 24-bit GRB pixel assembly and latch-period frame boundaries.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int THRESH_CYC = 30,
   parameter int MIN_HIGH   = 8,
   parameter int MAX_HIGH   = 60,
   parameter int RESET_CYC  = RESET_LOW
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        din,
   ws2812_rx_if.master rx
);

   localparam logic [1:0] SYNC = RX_SYNC;
   localparam logic [1:0] IDLE = RX_IDLE;
   localparam logic [1:0] HIGH = RX_HIGH;
   localparam logic [1:0] LOW  = RX_LOW;

   logic             lvl, rise, fall;
   logic [1:0]       state;
   logic [5:0]       hi_cnt;
   logic [11:0]      lo_cnt;
   logic [11:0]      lo_nxt;
   logic [GRB_W-2:0] shreg;
   logic [4:0]       bit_cnt;
   logic [7:0]       pix_cnt;
   logic             bit_val;
   logic             bad_w;

   sync_edge u_sync (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .din   (din),
      .level (lvl),
      .rise  (rise),
      .fall  (fall)
   );

   assign lo_nxt  = lo_cnt + 12'd1;
   assign bit_val = hi_cnt >= 6'(THRESH_CYC);
   assign bad_w   = (hi_cnt < 6'(MIN_HIGH)) ||
                    (hi_cnt > 6'(MAX_HIGH));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state         <= SYNC;
         hi_cnt        <= '0;
         lo_cnt        <= '0;
         shreg         <= '0;
         bit_cnt       <= '0;
         pix_cnt       <= '0;
         rx.pix_data   <= '0;
         rx.pix_valid  <= 1'b0;
         rx.pix_idx    <= '0;
         rx.frame_done <= 1'b0;
         rx.frame_len  <= '0;
         rx.bit_err    <= 1'b0;
      end else begin
         rx.pix_valid  <= 1'b0;
         rx.frame_done <= 1'b0;
         rx.bit_err    <= 1'b0;
         unique case (state)
            SYNC: begin
               if (lvl) begin
                  lo_cnt <= '0;
               end else if (lo_nxt == 12'(RESET_CYC)) begin
                  lo_cnt <= '0;
                  state  <= IDLE;
               end else begin
                  lo_cnt <= lo_nxt;
               end
            end
            IDLE: begin
               if (rise) begin
                  hi_cnt <= 6'd1;
                  state  <= HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  if (bad_w) begin
                     rx.bit_err <= 1'b1;
                     shreg      <= '0;
                     bit_cnt    <= '0;
                     pix_cnt    <= '0;
                     lo_cnt     <= '0;
                     state      <= SYNC;
                  end else begin
                     shreg <= {shreg[GRB_W-3:0], bit_val};
                     if (bit_cnt == 5'(GRB_W - 1)) begin
                        rx.pix_data  <= {shreg, bit_val};
                        rx.pix_valid <= 1'b1;
                        rx.pix_idx   <= pix_cnt;
                        if (pix_cnt != 8'hFF)
                           pix_cnt <= pix_cnt + 8'd1;
                        bit_cnt <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                     lo_cnt <= 12'd1;
                     state  <= LOW;
                  end
               end else if (hi_cnt <= 6'(MAX_HIGH)) begin
                  hi_cnt <= hi_cnt + 6'd1;
               end
            end
            LOW: begin
               if (rise) begin
                  hi_cnt <= 6'd1;
                  state  <= HIGH;
               end else if (lo_nxt == 12'(RESET_CYC)) begin
                  // latch period: partial pixel bits are dropped here
                  rx.frame_done <= 1'b1;
                  rx.frame_len  <= pix_cnt;
                  pix_cnt       <= '0;
                  bit_cnt       <= '0;
                  shreg         <= '0;
                  lo_cnt        <= '0;
                  state         <= IDLE;
               end else begin
                  lo_cnt <= lo_nxt;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed testbench for ws2812_rx: pixel decode, frame latch,
// glitch/width errors, threshold boundaries and mid-frame reset.
module tb_ws2812_rx;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic din     = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [23:0] q_data[$];
   logic [7:0]  q_idx[$];
   int          fd_cnt = 0;
   int          be_cnt = 0;
   int          both_cnt = 0;
   logic [7:0]  last_len = '0;

   ws2812_rx_if rx_if ();

   ws2812_rx dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .din     (din),
      .rx      (rx_if)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (rx_if.pix_valid) begin
         q_data.push_back(rx_if.pix_data);
         q_idx.push_back(rx_if.pix_idx);
      end
      if (rx_if.frame_done) begin
         fd_cnt++;
         last_len = rx_if.frame_len;
      end
      if (rx_if.bit_err)
         be_cnt++;
      if (rx_if.pix_valid && rx_if.frame_done)
         both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      q_data.delete();
      q_idx.delete();
      fd_cnt = 0;
      be_cnt = 0;
   endtask

   task automatic idle(input int n);
      din = 1'b0;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic pulse(input int h, input int l);
      din = 1'b1;
      repeat (h) @(posedge sys_clk);
      #1;
      din = 1'b0;
      repeat (l) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit fast);
      if (fast) pulse(b ? 31 : 12, 3);
      else      pulse(b ? 40 : 20, b ? 22 : 42);
   endtask

   task automatic send_pix(input logic [23:0] p, input bit fast);
      for (int i = 23; i >= 0; i--)
         send_bit(p[i], fast);
   endtask

   task automatic zeros(input int n);
      for (int i = 0; i < n; i++)
         send_bit(1'b0, 1'b1);
   endtask

   function automatic logic [23:0] pat(input int i);
      logic [7:0] a;
      a = 8'(i);
      return {a, ~a, 8'(i * 3)};
   endfunction

   initial begin
      logic [23:0] v;

      // reset values
      sys_rst = 1'b1;
      repeat (4) @(posedge sys_clk);
      #1;
      chk("rst_pix_data", 32'(rx_if.pix_data), 0);
      chk("rst_pix_valid", 32'(rx_if.pix_valid), 0);
      chk("rst_pix_idx", 32'(rx_if.pix_idx), 0);
      chk("rst_frame_done", 32'(rx_if.frame_done), 0);
      chk("rst_frame_len", 32'(rx_if.frame_len), 0);
      chk("rst_bit_err", 32'(rx_if.bit_err), 0);
      sys_rst = 1'b0;

      // activity before the line has idled long enough is ignored
      clr();
      send_pix(24'h5A5A5A, 1'b0);
      idle(2600);
      chk("sync_no_pix", q_data.size(), 0);
      chk("sync_no_err", be_cnt, 0);
      chk("sync_no_fd", fd_cnt, 0);

      // single pixel with nominal timing
      clr();
      send_pix(24'hFF0081, 1'b0);
      idle(2600);
      chk("p1_count", q_data.size(), 1);
      if (q_data.size() >= 1) begin
         chk("p1_data", 32'(q_data[0]), 32'hFF0081);
         chk("p1_idx", 32'(q_idx[0]), 0);
      end
      chk("p1_fd", fd_cnt, 1);
      chk("p1_len", 32'(last_len), 1);
      chk("p1_hold_len", 32'(rx_if.frame_len), 1);
      chk("p1_hold_data", 32'(rx_if.pix_data), 32'hFF0081);

      // 64-pixel loop-back frame
      clr();
      for (int i = 0; i < 64; i++)
         send_pix(pat(i), 1'b1);
      idle(2600);
      chk("lb_count", q_data.size(), 64);
      for (int i = 0; i < q_data.size() && i < 64; i++) begin
         chk($sformatf("lb_data%0d", i), 32'(q_data[i]), 32'(pat(i)));
         chk($sformatf("lb_idx%0d", i), 32'(q_idx[i]), i);
      end
      chk("lb_fd", fd_cnt, 1);
      chk("lb_len", 32'(last_len), 64);

      // 30 bits then latch: trailing 6 bits dropped
      clr();
      send_pix(24'hA5C33C, 1'b1);
      for (int i = 0; i < 6; i++)
         send_bit(i[0], 1'b1);
      idle(2600);
      chk("b30_count", q_data.size(), 1);
      if (q_data.size() >= 1)
         chk("b30_data", 32'(q_data[0]), 32'hA5C33C);
      chk("b30_fd", fd_cnt, 1);
      chk("b30_len", 32'(last_len), 1);

      // 5-cycle glitch mid-pixel
      clr();
      zeros(10);
      pulse(5, 3);
      zeros(14);
      idle(20);
      chk("gl_err", be_cnt, 1);
      chk("gl_no_pix", q_data.size(), 0);
      idle(2600);
      chk("gl_no_fd", fd_cnt, 0);
      clr();
      send_pix(24'h123456, 1'b1);
      idle(2600);
      chk("gl_rec_count", q_data.size(), 1);
      if (q_data.size() >= 1) begin
         chk("gl_rec_data", 32'(q_data[0]), 32'h123456);
         chk("gl_rec_idx", 32'(q_idx[0]), 0);
      end
      chk("gl_rec_len", 32'(last_len), 1);

      // threshold widths 29/31, max-valid 60, gap of 2499
      clr();
      zeros(22);
      pulse(29, 3);
      pulse(31, 3);
      idle(2499 - 3);
      pulse(60, 3);
      zeros(21);
      pulse(31, 3);
      pulse(29, 3);
      idle(2600);
      chk("th_count", q_data.size(), 2);
      if (q_data.size() >= 2) begin
         chk("th_data0", 32'(q_data[0]), 32'h000001);
         chk("th_idx0", 32'(q_idx[0]), 0);
         chk("th_data1", 32'(q_data[1]), 32'h800002);
         chk("th_idx1", 32'(q_idx[1]), 1);
      end
      chk("th_fd", fd_cnt, 1);
      chk("th_len", 32'(last_len), 2);
      chk("th_no_err", be_cnt, 0);

      // width 61 is too long
      clr();
      pulse(61, 10);
      chk("w61_err", be_cnt, 1);
      chk("w61_no_pix", q_data.size(), 0);
      idle(2600);

      // reset after 12 bits, then a fresh frame
      clr();
      for (int i = 0; i < 12; i++)
         send_bit(1'b1, 1'b1);
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      idle(2600);
      chk("mr_len_rst", 32'(rx_if.frame_len), 0);
      send_pix(24'hC0FFEE, 1'b1);
      send_pix(24'h0F1E2D, 1'b1);
      idle(2600);
      chk("mr_count", q_data.size(), 2);
      if (q_data.size() >= 2) begin
         chk("mr_data0", 32'(q_data[0]), 32'hC0FFEE);
         chk("mr_idx0", 32'(q_idx[0]), 0);
         chk("mr_data1", 32'(q_data[1]), 32'h0F1E2D);
         chk("mr_idx1", 32'(q_idx[1]), 1);
      end
      chk("mr_fd", fd_cnt, 1);
      chk("mr_len", 32'(last_len), 2);
      chk("pv_fd_overlap", both_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812 stream decoder: the receive end of the serial LED protocol that the LED-matrix transmitter drives. It samples the one-wire data line, classifies each high pulse as a 0 or 1 by its width, assembles 24-bit GRB pixel words MSB-first, and flags frame boundaries on the latch (reset) low period. It is used as a loop-back checker on the LED output pin and as the front end of any daisy-chained pixel consumer.

## Interface
- `THRESH_CYC`, 30: high-pulse width in cycles at or above which a bit is 1 (0.6 µs at 50 MHz).
- `MIN_HIGH`, 8: high pulses shorter than this are glitches and flag an error.
- `MAX_HIGH`, 60: high pulses longer than this flag an error.
- `RESET_CYC`, 2500: low time in cycles that ends a frame (50 µs at 50 MHz).
- `sys_clk`  in  1  single clock, 50 MHz nominal.
- `sys_rst`  in  1  synchronous, active-high reset.
- `din`  in  1  asynchronous WS2812 data line.
- `pix_data`  out  24  last complete pixel, {G,R,B}, bit 23 received first.
- `pix_valid`  out  1  one-cycle strobe when `pix_data` and `pix_idx` update.
- `pix_idx`  out  8  index of that pixel within its frame, 0-based, saturates at 255.
- `frame_done`  out  1  one-cycle strobe at frame end.
- `frame_len`  out  8  pixel count of the frame just ended, saturates at 255; valid with `frame_done`, held until next strobe.
- `bit_err`  out  1  one-cycle strobe on a malformed high pulse.

## Operation
- `din` passes through a 2-flop synchronizer plus a delay flop; rise/fall are detected on the synchronized signal.
- States: SYNC, IDLE, HIGH, LOW.
- SYNC (reset state): low counter runs while line low, clears on high; at `RESET_CYC` -> IDLE. Line activity before this is ignored; no strobes are issued.
- IDLE: rise -> HIGH, high counter = 1.
- HIGH: counter increments and saturates at `MAX_HIGH`+1. On fall:
  - width < `MIN_HIGH` or > `MAX_HIGH`: `bit_err`, drop shift register, bit count and pixel count, -> SYNC. No `frame_done`.
  - otherwise shift in (width >= `THRESH_CYC`). On the 24th bit, load `pix_data`, pulse `pix_valid`, `pix_idx` = pixel count, increment pixel count (saturating), clear bit count. -> LOW, low counter = 1.
- LOW: rise -> HIGH. Low gaps shorter than `RESET_CYC` are tolerated. Low counter reaching `RESET_CYC`:
  - pulse `frame_done`, `frame_len` = pixel count.
  - discard any partial pixel silently.
  - clear counts, -> IDLE.
- Width counting: high counter 6 bits, low counter 12 bits, both saturating, never wrapping.
- Reset mid-frame: all state is discarded and the block returns to SYNC. A frame already in progress is never reported.

## Timing
- Reset values: `pix_data` 0, `pix_valid` 0, `pix_idx` 0, `frame_done` 0, `frame_len` 0, `bit_err` 0, state SYNC.
- Synchronizer latency: the edge that first captures a new `din` level is edge N. The fall is detected combinationally in cycle N+1. Strobes (`pix_valid`, `bit_err`) are registered and high for the single cycle after edge N+2.
- High width counts synchronized-high cycles, so it equals the true width ±1 cycle. Thresholds carry this margin.
- `frame_done` is high in the cycle after the low counter reaches `RESET_CYC`. Its total delay from the last falling edge is `RESET_CYC`+3 cycles.
- `pix_valid` and `frame_done` never assert in the same cycle, since at least one low cycle separates them.
- `pix_data`, `pix_idx` and `frame_len` hold between strobes.

## Structure
- Shared package `ws2812_pkg` holds:
  - bit timing constants (T0H/T1H/period/reset cycles at 50 MHz), shared with the transmitter;
  - the `GRB_W` = 24 width;
  - the rx state enum.
- One sub-module: `sync_edge` (2-flop synchronizer + rise/fall detect), reusable for the gesture interrupt and key inputs.
- Counters, FSM and shift register stay in `ws2812_rx`.

## Test plan
- Idle low for 2500 cycles, then one pixel 0xFF0081 (T1H 40 / T0H 20, period 62), then low for 2500 cycles -> `pix_valid` once with `pix_data`=0xFF0081 and `pix_idx`=0; `frame_done` with `frame_len`=1.
- Loop-back of the LED transmitter sending 64 pixels of an incrementing pattern -> 64 `pix_valid` strobes, `pix_idx` 0..63, data matching, `frame_len`=64.
- 30 bits then latch -> exactly one pixel reported, the 6 trailing bits discarded, `frame_len`=1.
- 5-cycle glitch pulse mid-pixel -> `bit_err` one cycle, no `pix_valid`. After 2500 low cycles a following clean pixel decodes correctly.
- Threshold edges:
  - high widths 29 and 31 -> bit 0 and bit 1;
  - width 61 -> `bit_err`;
  - low gap of 2499 cycles between pixels -> the same frame continues.
- `sys_rst` asserted after 12 bits of a pixel, released, then a full frame -> the first partial pixel is never reported and the second frame decodes with `pix_idx` starting at 0.
